// File: rtl/front_pkg.sv
`default_nettype none
// ============================================================================
// Module   : front_pkg
// Purpose  : Shared types and defaults for the front-panel SPI arbiter.
//            Holds the FSM state encoding, the SPI word width, the default
//            gap and timeout constants, and a small pointer-wrap helper.
// Revision : 1.0  initial release
// ============================================================================
package front_pkg;

  localparam int SPI_WORD_W      = 24;
  localparam int DEF_TIMEOUT_CYC = 1024;
  localparam int DEF_GAP_CYC     = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    WAIT_LO = 3'd2,
    WAIT_HI = 3'd3,
    DONE    = 3'd4,
    GAP     = 3'd5
  } front_state_e;

  // Increment a requester index, wrapping at n.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/front_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : front_rr_pick
// Purpose  : Combinational one-hot round-robin picker. Scans the request
//            vector starting at ptr_i and returns the first asserted
//            requester as a one-hot grant plus its index.
// Revision : 1.0  initial release
// ============================================================================
module front_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [PTR_W-1:0]   idx_o,
  output logic               valid_o
);

  // Scan from the farthest offset down to the pointer so the closest hit wins.
  always_comb begin : p_pick
    int k;
    k       = 0;
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      k = (int'(ptr_i) + i) % NUM_REQ;
      if (req_i[k]) begin
        grant_o    = '0;
        grant_o[k] = 1'b1;
        idx_o      = k[PTR_W-1:0];
        valid_o    = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/front_spi_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : front_spi_arbiter
// Purpose  : Shares one front-panel SPI master between NUM_REQ requesters.
//            Grants one requester per transfer, forwards its MOSI word,
//            pulses the SPI start, routes n_cs to the owner's device and
//            returns the captured MISO word.
// Options  : FRONT_ARB_PRIO0_EN - requester 0 gets fixed highest priority
//            and the round-robin pointer only advances on grants to 1..N-1.
// Revision : 1.0  initial release
// ============================================================================
module front_spi_arbiter
  import front_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int WORD_W      = SPI_WORD_W,
  parameter int GAP_CYC     = DEF_GAP_CYC,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [NUM_REQ-1:0]        i_req,
  input  logic [NUM_REQ*WORD_W-1:0] i_req_data,
  output logic [NUM_REQ-1:0]        o_grant,
  output logic [NUM_REQ-1:0]        o_done,
  output logic [WORD_W-1:0]         o_rdata,
  output logic                      o_timeout,
  output logic                      o_busy,
  output logic                      o_spi_start,
  output logic [WORD_W-1:0]         o_mosi_data,
  input  logic [WORD_W-1:0]         i_miso_data,
  input  logic                      i_spi_cs,
  output logic [NUM_REQ-1:0]        o_dev_cs
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int TO_W  = $clog2(TIMEOUT_CYC);
  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  // The counter's next value reaching TIMEOUT_CYC-1 ends the wait, which puts
  // the registered timeout pulse exactly TIMEOUT_CYC cycles after START.
  localparam logic [TO_W-1:0]    TO_LAST     = TO_W'(TIMEOUT_CYC - 2);
  localparam logic [GAP_W-1:0]   GAP_LAST    = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [NUM_REQ-1:0] REQ0_ONEHOT = NUM_REQ'(1);
`ifdef FRONT_ARB_PRIO0_EN
  localparam bit PRIO0 = 1'b1;
`else
  localparam bit PRIO0 = 1'b0;
`endif

  front_state_e        state_q;
  logic [NUM_REQ-1:0]  grant_q;
  logic [PTR_W-1:0]    owner_q;
  logic [PTR_W-1:0]    ptr_q;
  logic [WORD_W-1:0]   mosi_q;
  logic [WORD_W-1:0]   rdata_q;
  logic [NUM_REQ-1:0]  done_q;
  logic                start_q;
  logic                timeout_q;
  logic [TO_W-1:0]     to_cnt_q;
  logic [GAP_W-1:0]    gap_cnt_q;

  logic [NUM_REQ-1:0]  pick_grant;
  logic [PTR_W-1:0]    pick_idx;
  logic                pick_valid;
  logic [NUM_REQ-1:0]  win_grant;
  logic [PTR_W-1:0]    win_idx;
  logic                win_valid;
  logic                cs_route;

  front_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_pick (
    .req_i   (i_req),
    .ptr_i   (ptr_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  // Winner selection: round-robin, optionally overridden by requester 0.
  always_comb begin
    win_grant = pick_grant;
    win_idx   = pick_idx;
    win_valid = pick_valid;
    if (PRIO0 && i_req[0]) begin
      win_grant = REQ0_ONEHOT;
      win_idx   = '0;
      win_valid = 1'b1;
    end
  end

  // Transfer sequencer with registered grant, data, start, done and timeout.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      owner_q   <= '0;
      ptr_q     <= '0;
      mosi_q    <= '0;
      rdata_q   <= '0;
      done_q    <= '0;
      start_q   <= 1'b0;
      timeout_q <= 1'b0;
      to_cnt_q  <= '0;
      gap_cnt_q <= '0;
    end else begin
      start_q   <= 1'b0;
      done_q    <= '0;
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (win_valid) begin
            grant_q <= win_grant;
            owner_q <= win_idx;
            mosi_q  <= i_req_data[int'(win_idx)*WORD_W +: WORD_W];
            start_q <= 1'b1;
            state_q <= START;
          end
        end
        START: begin
          to_cnt_q <= '0;
          state_q  <= WAIT_LO;
        end
        WAIT_LO: begin
          // A chip-select already low counts as the transfer in progress.
          if (!i_spi_cs) begin
            state_q <= WAIT_HI;
          end else if (to_cnt_q == TO_LAST) begin
            timeout_q <= 1'b1;
            grant_q   <= '0;
            gap_cnt_q <= '0;
            state_q   <= (GAP_CYC == 0) ? IDLE : GAP;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end
        WAIT_HI: begin
          if (i_spi_cs) begin
            rdata_q <= i_miso_data;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q    <= grant_q;
          grant_q   <= '0;
          gap_cnt_q <= '0;
          if (!PRIO0 || (owner_q != '0)) begin
            ptr_q <= PTR_W'(wrap_inc(int'(owner_q), NUM_REQ));
          end
          state_q <= (GAP_CYC == 0) ? IDLE : GAP;
        end
        GAP: begin
          if (gap_cnt_q == GAP_LAST) begin
            state_q <= IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Chip-select routing is live only while a transfer is on the wire, and
  // drops out the instant reset asserts.
  assign cs_route = !i_rst && ((state_q == WAIT_LO) || (state_q == WAIT_HI));

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_dev_cs
    assign o_dev_cs[k] = (cs_route && grant_q[k]) ? i_spi_cs : 1'b1;
  end

  assign o_grant     = grant_q;
  assign o_done      = done_q;
  assign o_rdata     = rdata_q;
  assign o_timeout   = timeout_q;
  assign o_busy      = (state_q != IDLE);
  assign o_spi_start = start_q;
  assign o_mosi_data = mosi_q;

endmodule
`default_nettype wire

// File: tb/tb_front_spi_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_front_spi_arbiter
// Purpose  : Directed self-checking bench for front_spi_arbiter with a
//            simple SPI master model (cs low 3 cycles after start, high
//            24 cycles later) and an event monitor.
// Options  : FRONT_ARB_PRIO0_EN changes the expected fixed-priority order.
// Revision : 1.0  initial release
// ============================================================================
module tb_front_spi_arbiter;

  localparam int N   = 4;
  localparam int W   = 24;
  localparam int GAP = 4;
  localparam int TMO = 1024;

  logic             r_clk = 1'b0;
  logic             r_rst = 1'b1;
  logic [N-1:0]     r_req;
  logic [N*W-1:0]   r_req_data;
  logic [W-1:0]     r_miso;
  logic             r_spi_cs;
  logic             r_spi_hang;
  logic [W-1:0]     r_miso_val;

  logic [N-1:0]     w_grant;
  logic [N-1:0]     w_done;
  logic [W-1:0]     w_rdata;
  logic             w_timeout;
  logic             w_busy;
  logic             w_spi_start;
  logic [W-1:0]     w_mosi;
  logic [N-1:0]     w_dev_cs;

  int n_vec = 0;
  int n_err = 0;

  always #5 r_clk = ~r_clk;

  front_spi_arbiter #(
    .NUM_REQ     (N),
    .WORD_W      (W),
    .GAP_CYC     (GAP),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .i_clk       (r_clk),
    .i_rst       (r_rst),
    .i_req       (r_req),
    .i_req_data  (r_req_data),
    .o_grant     (w_grant),
    .o_done      (w_done),
    .o_rdata     (w_rdata),
    .o_timeout   (w_timeout),
    .o_busy      (w_busy),
    .o_spi_start (w_spi_start),
    .o_mosi_data (w_mosi),
    .i_miso_data (r_miso),
    .i_spi_cs    (r_spi_cs),
    .o_dev_cs    (w_dev_cs)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Cycle counter
  int r_cyc = 0;
  initial forever begin
    @(posedge r_clk);
    r_cyc++;
  end

  // SPI master model
  initial begin
    r_spi_cs = 1'b1;
    r_miso   = '0;
    forever begin
      @(posedge r_clk);
      #1;
      if (w_spi_start === 1'b1 && !r_spi_hang) begin
        repeat (3) @(posedge r_clk);
        #1;
        r_spi_cs = 1'b0;
        repeat (24) @(posedge r_clk);
        #1;
        r_miso   = r_miso_val;
        r_spi_cs = 1'b1;
      end
    end
  end

  // Event monitor, sampled on the falling edge
  int           n_start = 0, n_done = 0, n_tmo = 0, start_long = 0, cs_bad = 0;
  logic [N-1:0] g_at_start[$];
  int           c_start[$];
  int           d_cyc[$];
  logic [W-1:0] mosi_at_start;
  logic [N-1:0] last_done;
  int           done_cyc, tmo_cyc, cs_rise_cyc;
  logic [N-1:0] devcs_low, grant_at_tmo, devcs_at_tmo;
  logic         prev_start = 1'b0, prev_cs = 1'b1;

  initial forever begin
    @(negedge r_clk);
    if (w_spi_start) begin
      if (prev_start) start_long++;
      else begin
        n_start++;
        g_at_start.push_back(w_grant);
        c_start.push_back(r_cyc);
        mosi_at_start = w_mosi;
      end
    end
    prev_start = w_spi_start;
    if (w_done != '0) begin
      n_done++;
      last_done = w_done;
      done_cyc  = r_cyc;
      d_cyc.push_back(r_cyc);
    end
    if (w_timeout) begin
      n_tmo++;
      tmo_cyc      = r_cyc;
      grant_at_tmo = w_grant;
      devcs_at_tmo = w_dev_cs;
    end
    if (!r_spi_cs) devcs_low = w_dev_cs;
    if (r_spi_cs && !prev_cs) cs_rise_cyc = r_cyc;
    prev_cs = r_spi_cs;
    if ((~w_dev_cs & ~w_grant) != '0) cs_bad++;
    if (r_spi_cs && (w_dev_cs != '1)) cs_bad++;
  end

  task automatic wait_done(input int target, input int maxc, input string tag);
    int i = 0;
    while (n_done < target && i < maxc) begin
      @(posedge r_clk);
      #1;
      i++;
    end
    if (n_done < target) chk(tag, n_done, target);
  endtask

  task automatic wait_idle(input string tag);
    int i = 0;
    while (w_busy && i < 100) begin
      @(posedge r_clk);
      #1;
      i++;
    end
    if (w_busy) chk(tag, w_busy, 1'b0);
  endtask

  task automatic wait_cs_low(input int k, input string tag);
    int i = 0;
    while (w_dev_cs[k] !== 1'b0 && i < 60) begin
      @(posedge r_clk);
      #2;
      i++;
    end
    if (w_dev_cs[k] !== 1'b0) chk(tag, w_dev_cs[k], 1'b0);
  endtask

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd, nt, req_cyc, i;
    logic [N-1:0] exp_g[5];
    logic [N-1:0] exp_first, exp_second;
    r_req      = '0;
    r_spi_hang = 1'b0;
    r_miso_val = '0;
    r_req_data = '0;
    r_req_data[0*W +: W] = 24'h111111;
    r_req_data[1*W +: W] = 24'hA55A01;
    r_req_data[2*W +: W] = 24'h222222;
    r_req_data[3*W +: W] = 24'h333333;

    // Reset state
    @(negedge r_clk);
    chk("rst_grant", w_grant, 4'b0000);
    chk("rst_busy", w_busy, 1'b0);
    chk("rst_devcs", w_dev_cs, 4'b1111);
    chk("rst_rdata", w_rdata, 24'h0);
    chk("rst_mosi", w_mosi, 24'h0);
    chk("rst_start", w_spi_start, 1'b0);
    repeat (2) @(posedge r_clk);
    #1 r_rst = 1'b0;
    @(posedge r_clk);
    #1;

    // Contention: all four held, pointer starts at 0
    r_miso_val = 24'hC0FFEE;
    r_req      = 4'b1111;
    wait_done(5, 300, "cont_wait");
    r_req = '0;
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int k = 0; k < 5; k++) chk($sformatf("cont_grant%0d", k), g_at_start[k], exp_g[k]);
    for (int k = 0; k < 4; k++) chk($sformatf("cont_gap%0d", k), 32'((c_start[k+1] - d_cyc[k]) >= GAP + 1), 1);
    wait_idle("cont_idle");

    // Single request from requester 1
    r_miso_val = 24'h001234;
    nd         = n_done;
    req_cyc    = r_cyc;
    r_req      = 4'b0010;
    wait_done(nd + 1, 100, "t1_wait");
    r_req = '0;
    chk("t1_start_lat", c_start[$] - req_cyc, 1);
    chk("t1_grant", g_at_start[$], 4'b0010);
    chk("t1_mosi", mosi_at_start, 24'hA55A01);
    chk("t1_devcs", devcs_low, 4'b1101);
    chk("t1_done", last_done, 4'b0010);
    chk("t1_rdata", w_rdata, 24'h001234);
    chk("t1_done_lat", done_cyc - cs_rise_cyc, 2);
    wait_idle("t1_idle");

    // Pointer at 2, requesters 0 and 2 together
`ifdef FRONT_ARB_PRIO0_EN
    exp_first  = 4'b0001;
    exp_second = 4'b0100;
`else
    exp_first  = 4'b0100;
    exp_second = 4'b0001;
`endif
    r_miso_val = 24'h0A0B0C;
    nd         = n_done;
    r_req      = 4'b0101;
    wait_done(nd + 1, 100, "t5_wait1");
    chk("t5_first", g_at_start[$], exp_first);
    chk("t5_mosi", mosi_at_start, (exp_first == 4'b0001) ? 24'h111111 : 24'h222222);
    r_req = r_req & ~last_done;
    wait_done(nd + 2, 100, "t5_wait2");
    chk("t5_second", g_at_start[$], exp_second);
    r_req = r_req & ~last_done;
    chk("t5_rdata", w_rdata, 24'h0A0B0C);
    wait_idle("t5_idle");

    // Owner drops its request while the transfer is on the wire
    r_miso_val = 24'h00ABCD;
    nd         = n_done;
    r_req      = 4'b0010;
    wait_cs_low(1, "t6_cs_wait");
    repeat (3) @(posedge r_clk);
    #1 r_req = '0;
    wait_done(nd + 1, 100, "t6_wait");
    chk("t6_done", last_done, 4'b0010);
    chk("t6_rdata", w_rdata, 24'h00ABCD);
    wait_idle("t6_idle");
    r_req = 4'b1010;
    wait_done(nd + 2, 100, "t6_wait2");
    chk("t6_ptr_adv", g_at_start[$], 4'b1000);
    r_req = r_req & ~last_done;
    wait_done(nd + 3, 100, "t6_wait3");
    chk("t6_next", g_at_start[$], 4'b0010);
    r_req = '0;
    wait_idle("t6_idle2");

    // Timeout: SPI model never lowers cs
    r_miso_val = 24'h777777;
    nd         = n_done;
    nt         = n_tmo;
    r_spi_hang = 1'b1;
    r_req      = 4'b0001;
    i = 0;
    while (n_tmo == nt && i < TMO + 100) begin
      @(posedge r_clk);
      #1;
      i++;
    end
    if (n_tmo == nt) chk("t3_wait", n_tmo, nt + 1);
    r_spi_hang = 1'b0;
    chk("t3_lat", tmo_cyc - c_start[$], TMO);
    chk("t3_grant", grant_at_tmo, 4'b0000);
    chk("t3_devcs", devcs_at_tmo, 4'b1111);
    chk("t3_nodone", n_done, nd);
    wait_done(nd + 1, 100, "t3_retry_wait");
    r_req = '0;
    chk("t3_retry", last_done, 4'b0001);
    chk("t3_tmo_cnt", n_tmo, nt + 1);
    chk("t3_rdata", w_rdata, 24'h777777);
    wait_idle("t3_idle");

    // Reset during the wait for cs high
    r_miso_val = 24'h5EED00;
    nd         = n_done;
    r_req      = 4'b0100;
    wait_cs_low(2, "t4_cs_wait");
    repeat (4) @(posedge r_clk);
    #1 r_rst = 1'b1;
    #1;
    chk("t4_grant", w_grant, 4'b0000);
    chk("t4_busy", w_busy, 1'b0);
    chk("t4_devcs", w_dev_cs, 4'b1111);
    chk("t4_rdata", w_rdata, 24'h0);
    chk("t4_mosi", w_mosi, 24'h0);
    chk("t4_start", w_spi_start, 1'b0);
    chk("t4_done", w_done, 4'b0000);
    chk("t4_tmo", w_timeout, 1'b0);
    r_req = '0;
    i = 0;
    while (!r_spi_cs && i < 40) begin
      @(posedge r_clk);
      #1;
      i++;
    end
    @(posedge r_clk);
    #1 r_rst = 1'b0;
    chk("t4_nodone", n_done, nd);
    r_miso_val = 24'h0BEEF1;
    r_req      = 4'b0100;
    wait_done(nd + 1, 100, "t4_wait");
    r_req = '0;
    chk("t4_after_grant", g_at_start[$], 4'b0100);
    chk("t4_after_done", last_done, 4'b0100);
    chk("t4_after_rdata", w_rdata, 24'h0BEEF1);
    wait_idle("t4_idle");

    // Chip-select routing and start pulse width over the whole run
    chk("cs_routing", cs_bad, 0);
    chk("start_width", start_long, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/front_spi_arbiter.md
Name: front_spi_arbiter

Overview:
- Shares the single front-panel SPI master (24-bit word, active-low n_cs) between up to NUM_REQ requesters, e.g. the LCD/SW sequencer, the RO encoder readout and future panel devices.
- Grants one requester per transfer, forwards its MOSI word and pulses the SPI start. It routes the master's n_cs to the owner's device chip-select and returns the captured MISO word.
- Sits between the FRONT top-level requesters and the SPI module, replacing fixed CS muxing.

Parameters:
- NUM_REQ, 4, number of requesters and device chip-selects (2..8).
- WORD_W, 24, SPI word width.
- GAP_CYC, 4, idle cycles enforced between consecutive transfers (0 allowed).
- TIMEOUT_CYC, 1024, maximum cycles to wait for n_cs to go low after start.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  reset.
- i_req  in  NUM_REQ  level request per requester; must be held until the matching o_done.
- i_req_data  in  NUM_REQ*WORD_W  MOSI word per requester; slice k = bits [k*WORD_W +: WORD_W].
- o_grant  out  NUM_REQ  one-hot owner, held from START through DONE.
- o_done  out  NUM_REQ  one-cycle pulse to the owner at transfer end.
- o_rdata  out  WORD_W  captured MISO word; updated with o_done and held.
- o_timeout  out  1  one-cycle pulse when the n_cs-low wait expires.
- o_busy  out  1  high in every state except IDLE.
- o_spi_start  out  1  one-cycle start pulse to the SPI module.
- o_mosi_data  out  WORD_W  owner's word, registered at grant and held.
- i_miso_data  in  WORD_W  SPI module receive word.
- i_spi_cs  in  1  SPI module n_cs (active-low), same clock domain.
- o_dev_cs  out  NUM_REQ  per-device n_cs, active-low.

Interface note: one clock; reset is asynchronous and active-high.

Behaviour:
- Reset values: o_grant=0, o_done=0, o_rdata=0, o_timeout=0, o_busy=0, o_spi_start=0, o_mosi_data=0. o_dev_cs all 1. RR pointer=0. State=IDLE.
- Reset mid-transfer aborts immediately. All chip-selects go high combinationally once reset asserts, and no o_done is issued.
- States:
  - IDLE: if any i_req, pick a winner by round-robin starting at the pointer; go to START.
  - START: one cycle. o_spi_start=1; o_grant and o_mosi_data are already registered. Go to WAIT_LO.
  - WAIT_LO: wait for i_spi_cs==0, then go to WAIT_HI. If the timeout counter reaches TIMEOUT_CYC-1, pulse o_timeout, clear o_grant, go to GAP. No o_done is issued; the requester may retry.
  - WAIT_HI: on the first cycle i_spi_cs==1, register i_miso_data into o_rdata and go to DONE.
  - DONE: o_done[owner]=1 for one cycle. Pointer becomes owner+1, mod NUM_REQ. Clear o_grant; go to GAP, or go straight to IDLE if GAP_CYC==0.
  - GAP: count GAP_CYC cycles, then go to IDLE.
- Latency: i_req rising in IDLE at cycle 0 gives o_grant and o_mosi_data valid at cycle 1 and o_spi_start at cycle 1. o_done comes 2 cycles after i_spi_cs returns high: capture, then pulse.
- CS routing is combinational: o_dev_cs[k] = i_spi_cs when o_grant[k] and state is WAIT_LO or WAIT_HI; otherwise 1. Non-owners are never driven low.
- Requests that drop before grant are ignored. If the owner drops i_req mid-transfer, the transfer still completes and o_done is still pulsed.
- Simultaneous requests: round-robin only; the pointer guarantees each requester is served within NUM_REQ transfers.
- An owner still asserting i_req in DONE is treated as a new request at the next IDLE and has lowest priority.
- Timeout counter is WORD-independent: clog2(TIMEOUT_CYC) bits, cleared on entry to WAIT_LO.
- i_spi_cs already low in START is treated as a transfer in progress; WAIT_LO exits on its first cycle.

Optional Feature:
- FRONT_ARB_PRIO0_EN defined: requester 0 (switch-interrupt service) has fixed highest priority. It wins whenever asserted in IDLE, and the RR pointer advances only on grants to requesters 1..NUM_REQ-1.
- Not defined: pure round-robin over all requesters.

Decomposition:
- Package front_pkg holds:
  - the state enum (IDLE, START, WAIT_LO, WAIT_HI, DONE, GAP);
  - SPI_WORD_W=24;
  - the default TIMEOUT_CYC and GAP_CYC constants.
- One sub-module, front_rr_pick: combinational one-hot round-robin picker taking request vector and pointer, returning one-hot grant and index.

Test Plan:
1. Single request: i_req=4'b0010, data1=24'hA5_5A_01; SPI model drops cs at start+3 and raises it 24 cycles later with miso=24'h00_12_34.
   - Expect o_spi_start one cycle, o_mosi_data=24'hA55A01, o_dev_cs=4'b1101 while cs is low, o_done=4'b0010, o_rdata=24'h001234.
2. Contention: i_req=4'b1111 held continuously.
   - Expect grant order 0,1,2,3,0, each transfer separated by ≥GAP_CYC+1 idle cycles.
3. Timeout: the SPI model never drops cs.
   - Expect o_timeout pulse exactly TIMEOUT_CYC cycles after START, no o_done, all o_dev_cs=1, next request still served.
4. Reset mid-transfer: assert i_rst during WAIT_HI.
   - Expect all outputs at reset values the same cycle and o_dev_cs=4'b1111; after release, a new request completes normally.
5. FRONT_ARB_PRIO0_EN: pointer at 2, i_req=4'b0101.
   - Expect requester 0 granted first, then requester 2; without the macro, requester 2 is granted first.
6. Owner drops i_req in WAIT_HI.
   - Expect transfer to complete with an o_done pulse, and the pointer to advance.
